// File: rtl/tlc_fsm.sv
// Two-road traffic-light controller with a latched pedestrian request that
// inserts an all-red phase after the current yellow.
//
// state | meaning
// S_AG  | road A green, road B red
// S_AY  | road A yellow, road B red
// S_BG  | road A red, road B green
// S_BY  | road A red, road B yellow
// S_PED | all red, pedestrians cross
module tlc_fsm #(
   parameter int GREEN_TIME  = 5,
   parameter int YELLOW_TIME = 2,
   parameter int PED_TIME    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ped_req,
   output logic [1:0] rA,
   output logic [1:0] rB
);

   typedef enum logic [2:0] {
      S_AG  = 3'd0,
      S_AY  = 3'd1,
      S_BG  = 3'd2,
      S_BY  = 3'd3,
      S_PED = 3'd4
   } state_t;

   localparam logic [1:0] LAMP_RED    = 2'b00;
   localparam logic [1:0] LAMP_YELLOW = 2'b01;
   localparam logic [1:0] LAMP_GREEN  = 2'b10;

   localparam logic [3:0] GREEN_LD  = 4'(GREEN_TIME - 1);
   localparam logic [3:0] YELLOW_LD = 4'(YELLOW_TIME - 1);
   localparam logic [3:0] PED_LD    = 4'(PED_TIME - 1);

   state_t     state;
   logic [3:0] timer_display;
   logic       ped_pending;
   logic       ret_b;
   logic       ped_now;
   logic       tc;

   // a request on the final yellow cycle still counts as pending
   assign ped_now = ped_pending | ped_req;
   assign tc      = (timer_display == 4'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_AG;
         timer_display <= GREEN_LD;
         ped_pending   <= 1'b0;
         ret_b         <= 1'b0;
      end else begin
         if (ped_req && state != S_PED)
            ped_pending <= 1'b1;
         case (state)
            S_AG: begin
               if (tc) begin
                  state         <= S_AY;
                  timer_display <= YELLOW_LD;
               end else begin
                  timer_display <= timer_display - 4'd1;
               end
            end
            S_AY: begin
               if (tc) begin
                  ret_b <= 1'b1;
                  if (ped_now) begin
                     state         <= S_PED;
                     timer_display <= PED_LD;
                     ped_pending   <= 1'b0;
                  end else begin
                     state         <= S_BG;
                     timer_display <= GREEN_LD;
                  end
               end else begin
                  timer_display <= timer_display - 4'd1;
               end
            end
            S_BG: begin
               if (tc) begin
                  state         <= S_BY;
                  timer_display <= YELLOW_LD;
               end else begin
                  timer_display <= timer_display - 4'd1;
               end
            end
            S_BY: begin
               if (tc) begin
                  ret_b <= 1'b0;
                  if (ped_now) begin
                     state         <= S_PED;
                     timer_display <= PED_LD;
                     ped_pending   <= 1'b0;
                  end else begin
                     state         <= S_AG;
                     timer_display <= GREEN_LD;
                  end
               end else begin
                  timer_display <= timer_display - 4'd1;
               end
            end
            S_PED: begin
               if (tc) begin
                  state         <= ret_b ? S_BG : S_AG;
                  timer_display <= GREEN_LD;
               end else begin
                  timer_display <= timer_display - 4'd1;
               end
            end
            default: begin
               state         <= S_AG;
               timer_display <= GREEN_LD;
            end
         endcase
      end
   end

   always_comb begin
      rA = LAMP_RED;
      rB = LAMP_RED;
      case (state)
         S_AG:    rA = LAMP_GREEN;
         S_AY:    rA = LAMP_YELLOW;
         S_BG:    rB = LAMP_GREEN;
         S_BY:    rB = LAMP_YELLOW;
         default: begin
            rA = LAMP_RED;
            rB = LAMP_RED;
         end
      endcase
   end

endmodule

// File: tb/tb_tlc_fsm.sv
// Scoreboard bench for tlc_fsm: a phase/remaining-cycles reference model
// predicts each cycle; a monitor compares the DUT one step after each edge.
module tb_tlc_fsm;

   localparam int GT = 5;
   localparam int YT = 2;
   localparam int PT = 3;

   logic       clk;
   logic       rst;
   logic       ped_req;
   logic [1:0] rA;
   logic [1:0] rB;

   tlc_fsm #(.GREEN_TIME(GT), .YELLOW_TIME(YT), .PED_TIME(PT)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .ped_req (ped_req),
      .rA      (rA),
      .rB      (rB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic [3:0] tmr;
      logic [1:0] la;
      logic [1:0] lb;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ped_phases = 0;

   // reference model: phase index 0=AG 1=AY 2=BG 3=BY 4=PED
   int   dur[5]    = '{GT, YT, GT, YT, PT};
   int   lamp_a[5] = '{2, 1, 0, 0, 0};
   int   lamp_b[5] = '{0, 0, 2, 1, 0};
   int   ph   = 0;
   int   left = GT;     // cycles still to spend in ph, including the current one
   bit   pend = 0;
   bit   back_to_b = 0;

   task automatic model_edge(input logic req, input logic r);
      bit new_pend;
      int nxt;
      if (r) begin
         ph = 0; left = dur[0]; pend = 0; back_to_b = 0;
         return;
      end
      new_pend = pend | (req && ph != 4);
      if (left > 1) begin
         left--;
      end else begin
         case (ph)
            0: nxt = 1;
            2: nxt = 3;
            1: begin nxt = (pend || req) ? 4 : 2; back_to_b = 1; end
            3: begin nxt = (pend || req) ? 4 : 0; back_to_b = 0; end
            default: nxt = back_to_b ? 2 : 0;
         endcase
         if (nxt == 4) begin
            new_pend = 0;
            ped_phases++;
         end
         ph = nxt;
         left = dur[nxt];
      end
      pend = new_pend;
   endtask

   task automatic step(input logic req, input logic r);
      exp_t e;
      @(negedge clk);
      ped_req = req;
      rst     = r;
      model_edge(req, r);
      e.st  = 3'(ph);
      e.tmr = 4'(left - 1);
      e.la  = 2'(lamp_a[ph]);
      e.lb  = 2'(lamp_b[ph]);
      exp_q.push_back(e);
   endtask

   task automatic run_to(input int target_ph, input int target_left);
      int n = 0;
      while (!(ph == target_ph && left == target_left) && n < 200) begin
         step(1'b0, 1'b0);
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL run_to phase %0d: not reached within 200 cycles", target_ph);
      end
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (3'(u_dut.state) !== e.st || u_dut.timer_display !== e.tmr) begin
               errors++;
               $display("FAIL state_timer t=%0t: got state %0d timer %0d, expected state %0d timer %0d",
                        $time, 3'(u_dut.state), u_dut.timer_display, e.st, e.tmr);
            end
            checks++;
            if (rA !== e.la || rB !== e.lb) begin
               errors++;
               $display("FAIL lamps t=%0t: got rA %0d rB %0d, expected rA %0d rB %0d",
                        $time, rA, rB, e.la, e.lb);
            end
         end
      end
   end

   initial begin
      int peds_before;
      rst = 1'b1;
      ped_req = 1'b0;
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);

      // free run, two full cycles, no requests
      repeat (30) step(1'b0, 1'b0);

      // request during road A green
      run_to(0, 3);
      step(1'b1, 1'b0);
      repeat (16) step(1'b0, 1'b0);

      // request during road B green
      run_to(2, 4);
      step(1'b1, 1'b0);
      repeat (16) step(1'b0, 1'b0);

      // request only on the last A-yellow cycle
      run_to(1, 1);
      step(1'b1, 1'b0);
      checks++;
      if (ph != 4) begin
         errors++;
         $display("FAIL last_yellow_model: phase %0d, expected 4", ph);
      end
      repeat (8) step(1'b0, 1'b0);

      // repeated requests, then pulses during the pedestrian phase
      run_to(2, 5);
      peds_before = ped_phases;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      run_to(4, 3);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b0);
      checks++;
      if (ped_phases - peds_before != 1) begin
         errors++;
         $display("FAIL collapse_count: got %0d ped phases, expected 1", ped_phases - peds_before);
      end

      // reset in the middle of a pedestrian phase
      step(1'b1, 1'b0);
      run_to(4, 2);
      step(1'b1, 1'b1);
      repeat (20) step(1'b0, 1'b0);

      // reset with a pending request, request on the reset edge too
      run_to(0, 2);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      repeat (20) step(1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));

      @(negedge clk);
      ped_req = 1'b0;
      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
